llr_org_loader: RTL and testbench
=================================

Name: llr_org_loader

Overview:
- Upstream feeder for the port-1 RAM controller. It accepts one frame of Z channel LLRs on a valid/ready stream and requantizes each sample to LLR_W bits.
- It drives the org_* write interface and the flag_first_store pulse, filling RAM addresses 0..Z-1 exactly once per frame before VFU iterations begin.
- It sits between the channel input buffer and the RAM controller, under the top-level decode controller (start/done).

Parameters:
- Z, 64, lifting size (frame length per RAM); a power of two, at most 2^ADDR_W.
- IN_W, 8, input LLR width, signed two's complement.
- LLR_W, 4, stored LLR width, signed.
- ADDR_W, 8, org_addr width.
- SHIFT, 2, arithmetic right shift applied before saturation.

Ports:
- sys_clk  in  1  clock, all logic on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to load a frame; honoured only in IDLE.
- in_llr  in  IN_W  channel LLR sample.
- in_valid  in  1  in_llr is valid.
- in_ready  out  1  loader accepts a sample this cycle.
- flag_first_store  out  1  one-cycle pulse that arms the RAM controller's org path.
- org_addr  out  ADDR_W  write address, registered.
- org_data  out  LLR_W  quantized LLR, aligned one cycle after its org_addr.
- org_wr_en  out  1  write strobe, aligned with org_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame is fully written.

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - in_ready, flag_first_store, org_wr_en, busy and done are 0.
  - org_addr, org_data and the sample counter are 0.
- Reset mid-frame aborts the load immediately. No partial-frame recovery; the next start reloads from address 0.
- FSM states:
  - IDLE: start=1 goes to ARM; otherwise stay.
  - ARM: 1 cycle, flag_first_store=1; go to LOAD.
  - LOAD: in_ready=1. On each in_valid&in_ready handshake the counter increments. After the Z-th handshake, in_ready drops in the next cycle and the FSM goes to DRAIN.
  - DRAIN: exactly 2 cycles, letting the pipeline flush; go to DONE.
  - DONE: 1 cycle, done=1, org_addr<=0; go to IDLE.
- Pipeline for a handshake in cycle t with counter value k:
  - org_addr=k is visible in cycle t+1.
  - org_data=q(in_llr) and org_wr_en=1 are visible in cycle t+2.
  - This extra stage matches the RAM controller's one-cycle registering of org_addr.
- org_wr_en is 1 only for cycles carrying a real sample. Input stalls (in_valid=0) produce bubbles; org_addr holds its value during a stall.
- Quantization:
  - v = in_llr >>> SHIFT (arithmetic shift).
  - Saturate symmetrically to [-(2^(LLR_W-1)-1), +(2^(LLR_W-1)-1)], i.e. [-7,+7] for LLR_W=4.
  - The most-negative code (-8) is never produced.
- org_addr rule:
  - org_addr equals Z-1 only while carrying the last sample. It is forced to 0 in DONE.
  - It is therefore 0 throughout IDLE and ARM, so the downstream "last address" detector never sees a stale Z-1 when re-armed.
- start asserted in any state other than IDLE is ignored, not queued.
- The first write cycle is at least 2 cycles after the flag_first_store pulse.
- Samples beyond Z are not accepted because in_ready=0.
- Counter width is clog2(Z)+1. There is no wrap within a frame; it clears in DONE.

Optional Feature:
- Macro: LLR_SAT_CNT_EN.
- With the macro defined:
  - Adds output sat_cnt (clog2(Z)+1 bits), counting samples clipped by saturation in the current frame.
  - sat_cnt clears on ARM and holds its value after done until the next start.
- Without the macro: the port and its counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package ldpc_pkg holds:
  - the Z, LLR_W and ADDR_W constants;
  - the loader state enum (IDLE, ARM, LOAD, DRAIN, DONE);
  - an LLR_MAX/LLR_MIN saturation constant pair.
- One natural sub-module: llr_quant_sat, combinational shift-and-saturate from IN_W to LLR_W, reused later on the VFU output path.

Test Plan:
- Reset then start=1 with continuous in_valid and in_llr = k (0..63):
  - flag_first_store pulses exactly once.
  - 64 writes go to addresses 0..63 with data sat(k>>>2), e.g. address 40 receives 7.
  - done pulses 3 cycles after the last handshake.
- in_llr = 127, -128, -29, 5:
  - org_data = 7, -7, -8>>>0 saturated to -7, and 1 respectively.
  - Never 4'b1000.
- in_valid toggling 1,0,0,1...: org_wr_en bubbles match the stalls, addresses stay contiguous, and the total write count is 64.
- start held high during LOAD, plus a second start 1 cycle after done: the mid-frame start is ignored; the second frame reloads from address 0, with org_addr=0 during ARM.
- sys_rst asserted after 30 writes: all outputs return to 0 asynchronously; a subsequent start writes addresses 0..63 cleanly.
- With LLR_SAT_CNT_EN and a frame containing 10 samples with |in_llr|>=32: sat_cnt=10 at done; it clears at the next ARM.

Source files
------------

// File: rtl/ldpc_pkg.sv
// ldpc_pkg
// Shared constants and types for the LDPC decoder datapath.
//   Z       : lifting size (frame length per RAM)
//   IN_W    : channel LLR width (signed)
//   LLR_W   : stored LLR width (signed)
//   ADDR_W  : RAM address width
//   SHIFT   : arithmetic right shift applied before saturation
//   LLR_MAX / LLR_MIN : symmetric saturation limits for stored LLRs
//   loader_state_e    : state encoding of the org loader FSM
package ldpc_pkg;

    localparam int Z      = 64;
    localparam int IN_W   = 8;
    localparam int LLR_W  = 4;
    localparam int ADDR_W = 8;
    localparam int SHIFT  = 2;
    localparam int CNT_W  = $clog2(Z) + 1;

    // Symmetric range: the most-negative code is never produced, so the
    // magnitude of every stored LLR fits in LLR_W-1 bits.
    localparam int LLR_MAX = (1 << (LLR_W - 1)) - 1;
    localparam int LLR_MIN = -LLR_MAX;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LOAD,
        DRAIN,
        DONE
    } loader_state_e;

    // Largest magnitude representable symmetrically in a w-bit signed LLR.
    function automatic int sat_limit(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/llr_org_loader_if.sv
// llr_org_loader_if
// Bundles the loader's input sample stream and its org_* write bus.
//   in_llr / in_valid / in_ready : channel sample stream (valid/ready)
//   flag_first_store             : one-cycle arm pulse towards the RAM controller
//   org_addr / org_data / org_wr_en : write port into the RAM controller
// Modports:
//   slave  : the loader's view (consumes samples, drives the org bus)
//   master : the environment's view (feeds samples, observes the org bus)
interface llr_org_loader_if #(
    parameter int IN_W   = ldpc_pkg::IN_W,
    parameter int LLR_W  = ldpc_pkg::LLR_W,
    parameter int ADDR_W = ldpc_pkg::ADDR_W
);

    logic [IN_W-1:0]   in_llr;
    logic              in_valid;
    logic              in_ready;
    logic              flag_first_store;
    logic [ADDR_W-1:0] org_addr;
    logic [LLR_W-1:0]  org_data;
    logic              org_wr_en;

    modport master (
        output in_llr,
        output in_valid,
        input  in_ready,
        input  flag_first_store,
        input  org_addr,
        input  org_data,
        input  org_wr_en
    );

    modport slave (
        input  in_llr,
        input  in_valid,
        output in_ready,
        output flag_first_store,
        output org_addr,
        output org_data,
        output org_wr_en
    );

endinterface

// File: rtl/llr_quant_sat.sv
// llr_quant_sat
// Combinational requantizer: arithmetic right shift by SHIFT, then
// symmetric saturation to +/-(2^(LLR_W-1)-1).
//   llr_i : IN_W-bit signed input LLR
//   llr_o : LLR_W-bit signed requantized LLR
module llr_quant_sat #(
    parameter int IN_W  = ldpc_pkg::IN_W,
    parameter int LLR_W = ldpc_pkg::LLR_W,
    parameter int SHIFT = ldpc_pkg::SHIFT
) (
    input  logic signed [IN_W-1:0]  llr_i,
    output logic signed [LLR_W-1:0] llr_o
);

    import ldpc_pkg::*;

    localparam int MAXV = sat_limit(LLR_W);
    localparam logic signed [IN_W-1:0] HI = IN_W'(MAXV);
    localparam logic signed [IN_W-1:0] LO = IN_W'(-MAXV);

    logic signed [IN_W-1:0] shifted;

    assign shifted = llr_i >>> SHIFT;

    // Clamp to the symmetric range; in-range values keep their low bits.
    always_comb begin
        llr_o = shifted[LLR_W-1:0];
        if (shifted > HI) begin
            llr_o = HI[LLR_W-1:0];
        end else if (shifted < LO) begin
            llr_o = LO[LLR_W-1:0];
        end
    end

endmodule

// File: rtl/llr_org_loader.sv
// llr_org_loader
// Loads one frame of Z channel LLRs into RAM addresses 0..Z-1 through the
// org_* write bus, requantizing every sample to LLR_W bits.
// Ports:
//   sys_clk, sys_rst : clock (rising edge) and asynchronous active-high reset
//   start            : one-cycle frame request, honoured only in IDLE
//   busy             : high in every state except IDLE
//   done             : one-cycle pulse once the frame is fully written
//   sat_cnt          : samples clipped in the current frame (LLR_SAT_CNT_EN only)
//   bus (slave)      : in_llr/in_valid/in_ready stream, flag_first_store,
//                      org_addr/org_data/org_wr_en write port
// Optional build macro: LLR_SAT_CNT_EN adds the sat_cnt output and counter.
module llr_org_loader #(
    parameter int Z      = ldpc_pkg::Z,
    parameter int IN_W   = ldpc_pkg::IN_W,
    parameter int LLR_W  = ldpc_pkg::LLR_W,
    parameter int ADDR_W = ldpc_pkg::ADDR_W,
    parameter int SHIFT  = ldpc_pkg::SHIFT,
    parameter int CNT_W  = $clog2(Z) + 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
`ifdef LLR_SAT_CNT_EN
    output logic [CNT_W-1:0] sat_cnt,
`endif
    llr_org_loader_if.slave  bus
);

    import ldpc_pkg::*;

    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain_q, drain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Stage 1 holds the quantized sample while its address is on org_addr;
    // stage 2 presents it on org_data together with the write strobe.
    logic              s1_valid_q;
    logic [LLR_W-1:0]  s1_data_q;
    logic              wr_en_q;
    logic [LLR_W-1:0]  data_q;

    logic              hs;
    logic              in_ready_c;
    logic              flag_c;
    logic              done_c;
    logic [LLR_W-1:0]  quant_llr;

    llr_quant_sat #(
        .IN_W  (IN_W),
        .LLR_W (LLR_W),
        .SHIFT (SHIFT)
    ) u_quant (
        .llr_i (bus.in_llr),
        .llr_o (quant_llr)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drain_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state and decoded outputs. in_ready is a pure state decode, so it
    // falls in the cycle after the Z-th handshake when the FSM enters DRAIN.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = 1'b0;
        addr_d     = addr_q;
        hs         = 1'b0;
        in_ready_c = 1'b0;
        flag_c     = 1'b0;
        done_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                flag_c  = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    hs     = 1'b1;
                    cnt_d  = cnt_q + CNT_W'(1);
                    addr_d = ADDR_W'(cnt_q);
                    if (cnt_q == CNT_W'(Z - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Two cycles: let the last sample leave stage 2.
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                cnt_d   = '0;
                addr_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
        end else begin
            s1_valid_q <= hs;
            s1_data_q  <= quant_llr;
            wr_en_q    <= s1_valid_q;
            data_q     <= s1_data_q;
        end
    end

`ifdef LLR_SAT_CNT_EN
    logic [CNT_W-1:0] sat_q, sat_d;
    logic             sat_hit;

    // A sample was clipped iff the shifted value differs from the stored one.
    assign sat_hit = (($signed(bus.in_llr) >>> SHIFT) != IN_W'($signed(quant_llr)));

    always_comb begin
        sat_d = sat_q;
        if (state_q == ARM) begin
            sat_d = '0;
        end else if (hs && sat_hit) begin
            sat_d = sat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sat_q <= '0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_cnt = sat_q;
`endif

    assign bus.in_ready         = in_ready_c;
    assign bus.flag_first_store = flag_c;
    assign bus.org_addr         = addr_q;
    assign bus.org_data         = data_q;
    assign bus.org_wr_en        = wr_en_q;
    assign busy                 = (state_q != IDLE);
    assign done                 = done_c;

endmodule

// File: tb/tb_llr_org_loader.sv
// tb_llr_org_loader
// Self-checking bench for llr_org_loader. A negedge monitor pushes the
// expected (address, data) of every accepted sample into a scoreboard and
// pops/compares it when org_wr_en shows the write. Define LLR_SAT_CNT_EN
// to also exercise the saturation counter.
module tb_llr_org_loader;

    import ldpc_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic start   = 1'b0;
    logic busy;
    logic done;
`ifdef LLR_SAT_CNT_EN
    logic [CNT_W-1:0] sat_cnt;
`endif

    llr_org_loader_if bus ();

    llr_org_loader dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
`ifdef LLR_SAT_CNT_EN
        .sat_cnt (sat_cnt),
`endif
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int               addr;
        logic [LLR_W-1:0] data;
    } exp_t;

    exp_t             sb[$];
    int               total = 0;
    int               bad   = 0;
    int               cyc   = 0;
    int               hs_idx, wr_count, flag_count, done_count, sat_exp;
    int               first_hs_cyc, last_hs_cyc, first_wr_cyc, last_wr_cyc;
    int               flag_cyc, done_cyc;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [LLR_W-1:0] mem [Z];

    always @(posedge sys_clk) cyc++;

    function automatic logic [LLR_W-1:0] model_q(input int x);
        int v;
        v = x >>> 2;
        if (v > 7)  v = 7;
        if (v < -7) v = -7;
        return LLR_W'(v);
    endfunction

    function automatic int gen(input int mode, input int k);
        int r;
        case (mode)
            0: r = k;
            1: begin
                case (k % 4)
                    0:       r = 127;
                    1:       r = -128;
                    2:       r = -29;
                    default: r = 5;
                endcase
            end
            2: r = int'($urandom_range(0, 255)) - 128;
            default: r = (k < 10) ? ((k % 2 == 1) ? 40 : -40) : (k % 8) - 4;
        endcase
        return r;
    endfunction

    // Scoreboard monitor: push on handshake, pop/compare on write strobe.
    always @(negedge sys_clk) begin
        exp_t e;
        int   x;
        if (!sys_rst) begin
            if (bus.in_valid && bus.in_ready) begin
                x      = int'($signed(bus.in_llr));
                e.addr = hs_idx;
                e.data = model_q(x);
                sb.push_back(e);
                if ((x >>> 2) > 7 || (x >>> 2) < -7) sat_exp++;
                if (hs_idx == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                hs_idx++;
            end
            if (bus.org_wr_en) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL sb_extra_write got addr=%0d data=%0d, required no write",
                             prev_addr, bus.org_data);
                end else begin
                    e = sb.pop_front();
                    if (prev_addr !== ADDR_W'(e.addr) || bus.org_data !== e.data) begin
                        bad++;
                        $display("[TB] FAIL sb_write got addr=%0d data=%0d, required addr=%0d data=%0d",
                                 prev_addr, bus.org_data, e.addr, e.data);
                    end
                end
                total++;
                if (bus.org_data === 4'b1000) begin
                    bad++;
                    $display("[TB] FAIL no_min_code got data=%b, required not 1000", bus.org_data);
                end
                if (int'(prev_addr) < Z) mem[prev_addr[$clog2(Z)-1:0]] = bus.org_data;
                if (wr_count == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_count++;
            end
            if (bus.flag_first_store) begin
                flag_count++;
                flag_cyc = cyc;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
        prev_addr = bus.org_addr;
    end

    task automatic clear_frame();
        hs_idx     = 0;
        wr_count   = 0;
        flag_count = 0;
        done_count = 0;
        sat_exp    = 0;
        sb.delete();
        for (int i = 0; i < Z; i++) mem[i] = 4'b1000;
    endtask

    task automatic start_frame(input bit hold);
        @(posedge sys_clk); #1 start = 1'b1;
        @(posedge sys_clk); #1 start = hold;
    endtask

    // Feeds samples until Z are accepted (or abort_after writes have been seen).
    task automatic feed(input int mode, input int stall, input int abort_after, output int k);
        int  step;
        bit  hs;
        k    = 0;
        step = 0;
        while (k < Z && step < 4000) begin
            if (abort_after > 0 && wr_count >= abort_after) break;
            bus.in_llr   = IN_W'(gen(mode, k));
            bus.in_valid = (stall == 0) ? 1'b1 : (step % 3 == 0);
            hs = bus.in_valid && bus.in_ready;
            @(posedge sys_clk); #1;
            if (hs) k++;
            step++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        int d0;
        d0   = done_count;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk); #1;
            if (done_count > d0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if ({bus.in_ready, bus.flag_first_store, bus.org_wr_en, busy, done} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got %b, required 00000",
                     {bus.in_ready, bus.flag_first_store, bus.org_wr_en, busy, done});
        end
        total++;
        if (bus.org_addr !== '0) begin
            bad++;
            $display("[TB] FAIL reset_addr got %0d, required 0", bus.org_addr);
        end
        total++;
        if (bus.org_data !== '0) begin
            bad++;
            $display("[TB] FAIL reset_data got %0d, required 0", bus.org_data);
        end
        @(posedge sys_clk); #2 sys_rst = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_busy got %b, required 0", busy);
        end
    endtask

    task automatic test_ramp();
        int k;
        bit seen;
        clear_frame();
        start_frame(1'b0);
        feed(0, 0, 0, k);
        wait_done(seen);
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL ramp_done got none, required done pulse"); end
        total++;
        if (k != Z) begin bad++; $display("[TB] FAIL ramp_accept got %0d, required %0d", k, Z); end
        total++;
        if (flag_count != 1) begin bad++; $display("[TB] FAIL ramp_flag got %0d, required 1", flag_count); end
        total++;
        if (wr_count != Z) begin bad++; $display("[TB] FAIL ramp_writes got %0d, required %0d", wr_count, Z); end
        total++;
        if (done_cyc - last_hs_cyc != 3) begin
            bad++;
            $display("[TB] FAIL ramp_done_lat got %0d, required 3", done_cyc - last_hs_cyc);
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("[TB] FAIL ramp_pending got %0d, required 0", sb.size()); end
        total++;
        if (mem[40] !== 4'd7) begin bad++; $display("[TB] FAIL ramp_addr40 got %0d, required 7", mem[40]); end
        total++;
        if (mem[3] !== 4'd0) begin bad++; $display("[TB] FAIL ramp_addr3 got %0d, required 0", mem[3]); end
        total++;
        if (mem[4] !== 4'd1) begin bad++; $display("[TB] FAIL ramp_addr4 got %0d, required 1", mem[4]); end
    endtask

    task automatic test_sat_values();
        int k;
        bit seen;
        clear_frame();
        start_frame(1'b0);
        feed(1, 0, 0, k);
        wait_done(seen);
        total++;
        if (mem[0] !== 4'b0111) begin bad++; $display("[TB] FAIL sat_pos got %b, required 0111", mem[0]); end
        total++;
        if (mem[1] !== 4'b1001) begin bad++; $display("[TB] FAIL sat_neg got %b, required 1001", mem[1]); end
        total++;
        if (mem[2] !== 4'b1001) begin bad++; $display("[TB] FAIL sat_m29 got %b, required 1001", mem[2]); end
        total++;
        if (mem[3] !== 4'b0001) begin bad++; $display("[TB] FAIL sat_five got %b, required 0001", mem[3]); end
        total++;
        if (wr_count != Z) begin bad++; $display("[TB] FAIL sat_writes got %0d, required %0d", wr_count, Z); end
    endtask

    task automatic test_stalls();
        int k;
        bit seen;
        clear_frame();
        start_frame(1'b0);
        feed(2, 1, 0, k);
        wait_done(seen);
        total++;
        if (!seen || wr_count != Z) begin
            bad++;
            $display("[TB] FAIL stall_writes got %0d done=%0d, required %0d done=1", wr_count, seen, Z);
        end
        total++;
        if (last_wr_cyc - first_wr_cyc != last_hs_cyc - first_hs_cyc) begin
            bad++;
            $display("[TB] FAIL stall_span got %0d, required %0d",
                     last_wr_cyc - first_wr_cyc, last_hs_cyc - first_hs_cyc);
        end
        total++;
        if (first_wr_cyc - first_hs_cyc != 2) begin
            bad++;
            $display("[TB] FAIL stall_latency got %0d, required 2", first_wr_cyc - first_hs_cyc);
        end
        total++;
        if (first_wr_cyc - flag_cyc < 2) begin
            bad++;
            $display("[TB] FAIL flag_to_write got %0d, required >=2", first_wr_cyc - flag_cyc);
        end
    endtask

    task automatic test_start_ignored();
        int k;
        bit seen;
        clear_frame();
        start_frame(1'b1);
        feed(0, 0, 0, k);
        start = 1'b0;
        wait_done(seen);
        total++;
        if (flag_count != 1 || wr_count != Z) begin
            bad++;
            $display("[TB] FAIL held_start got flags=%0d writes=%0d, required flags=1 writes=%0d",
                     flag_count, wr_count, Z);
        end
        clear_frame();
        start_frame(1'b0);
        total++;
        if (bus.flag_first_store !== 1'b1 || bus.org_addr !== '0) begin
            bad++;
            $display("[TB] FAIL rearm got flag=%b addr=%0d, required flag=1 addr=0",
                     bus.flag_first_store, bus.org_addr);
        end
        feed(0, 0, 0, k);
        wait_done(seen);
        total++;
        if (!seen || wr_count != Z || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL reload got writes=%0d done=%0d pending=%0d, required %0d/1/0",
                     wr_count, seen, sb.size(), Z);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        bit seen;
        clear_frame();
        start_frame(1'b0);
        feed(0, 0, 30, k);
        #2 sys_rst = 1'b1;
        #1;
        total++;
        if ({bus.in_ready, bus.flag_first_store, bus.org_wr_en, busy, done} !== 5'b0
            || bus.org_addr !== '0 || bus.org_data !== '0) begin
            bad++;
            $display("[TB] FAIL midreset got ctrl=%b addr=%0d data=%0d, required all 0",
                     {bus.in_ready, bus.flag_first_store, bus.org_wr_en, busy, done},
                     bus.org_addr, bus.org_data);
        end
        sb.delete();
        @(posedge sys_clk); #2 sys_rst = 1'b0;
        clear_frame();
        start_frame(1'b0);
        feed(0, 0, 0, k);
        wait_done(seen);
        total++;
        if (!seen || wr_count != Z || sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL post_reset got writes=%0d done=%0d pending=%0d, required %0d/1/0",
                     wr_count, seen, sb.size(), Z);
        end
        total++;
        if (mem[63] !== 4'd7) begin bad++; $display("[TB] FAIL post_reset_63 got %0d, required 7", mem[63]); end
    endtask

`ifdef LLR_SAT_CNT_EN
    task automatic test_sat_cnt();
        int k;
        bit seen;
        clear_frame();
        start_frame(1'b0);
        feed(3, 0, 0, k);
        wait_done(seen);
        total++;
        if (sat_cnt !== CNT_W'(10)) begin bad++; $display("[TB] FAIL sat_cnt got %0d, required 10", sat_cnt); end
        repeat (2) @(posedge sys_clk);
        #1;
        total++;
        if (sat_cnt !== CNT_W'(10)) begin bad++; $display("[TB] FAIL sat_hold got %0d, required 10", sat_cnt); end
        clear_frame();
        start_frame(1'b0);
        @(posedge sys_clk); #1;
        total++;
        if (sat_cnt !== '0) begin bad++; $display("[TB] FAIL sat_clear got %0d, required 0", sat_cnt); end
        feed(0, 0, 0, k);
        wait_done(seen);
        total++;
        if (sat_cnt !== CNT_W'(32)) begin bad++; $display("[TB] FAIL sat_ramp got %0d, required 32", sat_cnt); end
    endtask
`endif

    initial begin
        bus.in_llr   = '0;
        bus.in_valid = 1'b0;
        test_reset();
        test_ramp();
        test_sat_values();
        test_stalls();
        test_start_ignored();
        test_reset_mid();
`ifdef LLR_SAT_CNT_EN
        test_sat_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
